// File: rtl/mac_pkg.sv
// Shared constants and saturation-limit helpers for the MAC lane and the accelerator top.
package mac_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ACC_WIDTH  = 32;
    localparam int MAX_ACC_WIDTH      = 128;

    typedef logic [MAX_ACC_WIDTH-1:0] wide_t;

    // What the accumulator does on the next edge, in priority order.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_ACCUM
    } acc_op_e;

    // Largest representable value of a width-bit accumulator; callers keep the low width bits.
    function automatic wide_t sat_max(input int width, input bit is_signed);
        return is_signed ? (wide_t'(1) << (width - 1)) - wide_t'(1)
                         : (wide_t'(1) << width) - wide_t'(1);
    endfunction

    // Smallest representable value; for signed widths the low width bits read 100...0.
    function automatic wide_t sat_min(input int width, input bit is_signed);
        return is_signed ? ~sat_max(width, 1'b1) : '0;
    endfunction

endpackage

// File: rtl/mac_mult.sv
// Combinational full-width multiplier; operands are sign- or zero-extended to 2*DATA_WIDTH first.
module mac_mult #(
    parameter int DATA_WIDTH = 32,
    parameter bit SIGNED     = 1'b1
) (
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [2*DATA_WIDTH-1:0] product
);

    logic [2*DATA_WIDTH-1:0] a_ext;
    logic [2*DATA_WIDTH-1:0] b_ext;

    // The low 2*DATA_WIDTH bits of an unsigned product of extended operands equal the signed product.
    assign a_ext   = {{DATA_WIDTH{SIGNED & a[DATA_WIDTH-1]}}, a};
    assign b_ext   = {{DATA_WIDTH{SIGNED & b[DATA_WIDTH-1]}}, b};
    assign product = a_ext * b_ext;

endmodule

// File: rtl/mac.sv
// Single multiply-accumulate lane: registered accumulator with clear, wrap/saturate and sticky overflow.
module mac
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
    parameter bit SIGNED     = 1'b1,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [ACC_WIDTH-1:0]  accum_out,
    output logic                  overflow
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH, SIGNED));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH, SIGNED));

    logic [1:0]           rst_pipe;
    logic                 rst_n;
    logic [PW-1:0]        product;
    logic [ACC_WIDTH-1:0] p_acc;
    logic                 p_lost;
    logic [ACC_WIDTH:0]   sum;
    logic                 sum_ovf;
    logic [ACC_WIDTH-1:0] sat_val;
    acc_op_e              op;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 ovf_next;

    // Assert asynchronously, release two clk edges after reset goes high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_pipe <= 2'b00;
        end else begin
            // NOTE: non-blocking here so both stages sample the pre-edge value, forming a real two-flop chain.
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    mac_mult #(
        .DATA_WIDTH(DATA_WIDTH),
        .SIGNED    (SIGNED)
    ) u_mult (
        .a      (a_in),
        .b      (b_in),
        .product(product)
    );

    generate
        if (ACC_WIDTH > PW) begin : g_extend
            assign p_acc  = {{(ACC_WIDTH - PW){SIGNED & product[PW-1]}}, product};
            assign p_lost = 1'b0;
        end else if (ACC_WIDTH == PW) begin : g_exact
            assign p_acc  = product;
            assign p_lost = 1'b0;
        end else begin : g_truncate
            logic [PW-ACC_WIDTH-1:0] p_high;
            assign p_acc  = product[ACC_WIDTH-1:0];
            assign p_high = product[PW-1:ACC_WIDTH];
            // Truncation is lossless only if the dropped bits are a pure extension of the kept MSB.
            assign p_lost = SIGNED ? (p_high != {(PW - ACC_WIDTH){product[ACC_WIDTH-1]}})
                                   : (|p_high);
        end
    endgenerate

    assign sum     = {SIGNED & accum_out[ACC_WIDTH-1], accum_out}
                   + {SIGNED & p_acc[ACC_WIDTH-1], p_acc};
    assign sum_ovf = SIGNED ? (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];
    // Bit ACC_WIDTH of the extended sum is the true sign, so it picks the clamp direction.
    assign sat_val = (SIGNED && sum[ACC_WIDTH]) ? ACC_MIN : ACC_MAX;

    always_comb begin
        op = OP_HOLD;
        if (clear) begin
            op = enable ? OP_LOAD : OP_CLEAR;
        end else if (enable) begin
            op = OP_ACCUM;
        end
    end

    always_comb begin
        // NOTE: defaulting every output first means no path leaves them unassigned, so no latch is inferred.
        acc_next = accum_out;
        ovf_next = overflow;
        unique case (op)
            OP_HOLD: begin
            end
            OP_CLEAR: begin
                acc_next = '0;
                ovf_next = 1'b0;
            end
            OP_LOAD: begin
                acc_next = p_acc;
                ovf_next = p_lost;
            end
            OP_ACCUM: begin
                acc_next = (sum_ovf && SATURATE) ? sat_val : sum[ACC_WIDTH-1:0];
                ovf_next = overflow | p_lost | sum_ovf;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accum_out <= '0;
            overflow  <= 1'b0;
        end else begin
            accum_out <= acc_next;
            overflow  <= ovf_next;
        end
    end

endmodule

// File: tb/tb_mac.sv
// Randomized bench for mac: four parameter variants checked every cycle against an arithmetic model.
module tb_mac;

    typedef logic signed [127:0] big_t;
    typedef struct {
        big_t acc;
        bit   ovf;
    } mstate_t;

    localparam int N_DUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        enable;
    logic [31:0] a;
    logic [31:0] b;

    logic [31:0] acc_w;
    logic [31:0] acc_s;
    logic [11:0] acc_u;
    logic [19:0] acc_x;
    logic        ovf_w;
    logic        ovf_s;
    logic        ovf_u;
    logic        ovf_x;

    int      checks = 0;
    int      errors = 0;
    bit      cmp_en = 1'b0;
    int      sync_cnt;
    mstate_t m [N_DUT];

    always #5 clk = ~clk;

    mac #(.DATA_WIDTH(32), .ACC_WIDTH(32), .SIGNED(1'b1), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable),
        .a_in(a), .b_in(b), .accum_out(acc_w), .overflow(ovf_w));

    mac #(.DATA_WIDTH(32), .ACC_WIDTH(32), .SIGNED(1'b1), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable),
        .a_in(a), .b_in(b), .accum_out(acc_s), .overflow(ovf_s));

    mac #(.DATA_WIDTH(8), .ACC_WIDTH(12), .SIGNED(1'b0), .SATURATE(1'b1)) u_uns (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable),
        .a_in(a[7:0]), .b_in(b[7:0]), .accum_out(acc_u), .overflow(ovf_u));

    mac #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(1'b1), .SATURATE(1'b0)) u_sx (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable),
        .a_in(a[7:0]), .b_in(b[7:0]), .accum_out(acc_x), .overflow(ovf_x));

    function automatic int dw_of(input int i);
        return (i < 2) ? 32 : 8;
    endfunction

    function automatic int aw_of(input int i);
        case (i)
            0, 1:    return 32;
            2:       return 12;
            default: return 20;
        endcase
    endfunction

    function automatic bit sgn_of(input int i);
        return i != 2;
    endfunction

    function automatic bit sat_of(input int i);
        return (i == 1) || (i == 2);
    endfunction

    function automatic big_t pow2(input int n);
        big_t one = 1;
        return one << n;
    endfunction

    // Reduce x modulo 2^w into the representable range of a w-bit word.
    function automatic big_t wrap(input big_t x, input int w, input bit sgn);
        big_t r = x & (pow2(w) - 1);
        if (sgn && r[w-1]) r = r - pow2(w);
        return r;
    endfunction

    function automatic big_t lo_of(input int w, input bit sgn);
        return sgn ? -pow2(w - 1) : big_t'(0);
    endfunction

    function automatic big_t hi_of(input int w, input bit sgn);
        return sgn ? pow2(w - 1) - 1 : pow2(w) - 1;
    endfunction

    function automatic big_t operand(input logic [31:0] v, input int w, input bit sgn);
        big_t r = big_t'(v) & (pow2(w) - 1);
        if (sgn && r[w-1]) r = r - pow2(w);
        return r;
    endfunction

    function automatic mstate_t model_next(input int i, input mstate_t s, input bit c, input bit e,
                                           input logic [31:0] av, input logic [31:0] bv);
        int      dw  = dw_of(i);
        int      aw  = aw_of(i);
        bit      sg  = sgn_of(i);
        big_t    lo  = lo_of(aw, sg);
        big_t    hi  = hi_of(aw, sg);
        big_t    p   = operand(av, dw, sg) * operand(bv, dw, sg);
        bit      lost = (p < lo) || (p > hi);
        big_t    pv  = wrap(p, aw, sg);
        big_t    tot;
        bit      oor;
        mstate_t r  = s;
        if (c && e) begin
            r.acc = pv;
            r.ovf = lost;
        end else if (c) begin
            r.acc = 0;
            r.ovf = 1'b0;
        end else if (e) begin
            tot = s.acc + pv;
            oor = (tot < lo) || (tot > hi);
            if (oor && sat_of(i)) r.acc = (tot > hi) ? hi : lo;
            else                  r.acc = wrap(tot, aw, sg);
            r.ovf = s.ovf | lost | oor;
        end
        return r;
    endfunction

    // Model: accumulation starts only once the two-edge reset release has elapsed.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_cnt <= 0;
            for (int i = 0; i < N_DUT; i++) begin
                m[i].acc <= 0;
                m[i].ovf <= 1'b0;
            end
        end else if (sync_cnt < 2) begin
            sync_cnt <= sync_cnt + 1;
        end else begin
            for (int i = 0; i < N_DUT; i++) m[i] <= model_next(i, m[i], clear, enable, a, b);
        end
    end

    function automatic logic [63:0] get_acc(input int i);
        case (i)
            0:       return 64'(acc_w);
            1:       return 64'(acc_s);
            2:       return 64'(acc_u);
            default: return 64'(acc_x);
        endcase
    endfunction

    function automatic logic [63:0] get_ovf(input int i);
        case (i)
            0:       return 64'(ovf_w);
            1:       return 64'(ovf_s);
            2:       return 64'(ovf_u);
            default: return 64'(ovf_x);
        endcase
    endfunction

    function automatic logic [63:0] model_bits(input int i);
        big_t r = m[i].acc & (pow2(aw_of(i)) - 1);
        return r[63:0];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Hand-computed expectations pin both the DUT and the model.
    task automatic lit(input int i, input string name, input logic [63:0] exp_acc, input bit exp_ovf);
        check({name, " dut acc"}, get_acc(i), exp_acc);
        check({name, " dut ovf"}, get_ovf(i), 64'(exp_ovf));
        check({name, " model acc"}, model_bits(i), exp_acc);
        check({name, " model ovf"}, 64'(m[i].ovf), 64'(exp_ovf));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < N_DUT; i++) begin
                check($sformatf("cycle acc[%0d]", i), get_acc(i), model_bits(i));
                check($sformatf("cycle ovf[%0d]", i), get_ovf(i), 64'(m[i].ovf));
            end
        end
    end

    task automatic cyc(input bit c, input bit e, input logic [31:0] av, input logic [31:0] bv);
        clear  = c;
        enable = e;
        a      = av;
        b      = bv;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 255)) - 32'd128;
            2:       return $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return 32'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic random_run(input int n);
        for (int k = 0; k < n; k++)
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, rnd_op(), rnd_op());
    endtask

    initial begin
        reset  = 1'b0;
        clear  = 1'b0;
        enable = 1'b1;
        a      = 32'd5;
        b      = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        lit(0, "in reset", 64'd0, 1'b0);

        enable = 1'b0;
        reset  = 1'b1;
        cyc(1'b0, 1'b0, 32'd5, 32'd7);
        cyc(1'b0, 1'b0, 32'd5, 32'd7);
        cyc(1'b0, 1'b1, 32'd5, 32'd7);
        lit(0, "first after reset", 64'd35, 1'b0);

        cyc(1'b1, 1'b1, 32'd1, 32'd4);
        lit(0, "dot load", 64'd4, 1'b0);
        cyc(1'b0, 1'b1, 32'd2, 32'd5);
        lit(0, "dot step2", 64'd14, 1'b0);
        cyc(1'b0, 1'b1, 32'd3, 32'd6);
        lit(0, "dot step3", 64'd32, 1'b0);

        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, $urandom, $urandom);
            lit(0, "hold", 64'd32, 1'b0);
        end
        cyc(1'b1, 1'b0, $urandom, $urandom);
        lit(0, "clear", 64'd0, 1'b0);

        cyc(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd4);
        lit(0, "signed load", 64'hFFFF_FFF4, 1'b0);
        cyc(1'b0, 1'b1, 32'd2, 32'd6);
        lit(0, "signed add", 64'h0, 1'b0);

        cyc(1'b1, 1'b1, 32'h7FFF_FFFF, 32'd1);
        lit(0, "max load", 64'h7FFF_FFFF, 1'b0);
        cyc(1'b0, 1'b1, 32'd1, 32'd1);
        lit(0, "wrap", 64'h8000_0000, 1'b1);
        lit(1, "saturate", 64'h7FFF_FFFF, 1'b1);
        cyc(1'b1, 1'b0, 32'd0, 32'd0);
        lit(0, "wrap cleared", 64'd0, 1'b0);
        lit(1, "sat cleared", 64'd0, 1'b0);

        random_run(300);

        cyc(1'b1, 1'b1, 32'd3, 32'd3);
        clear  = 1'b0;
        enable = 1'b1;
        a      = 32'd1000;
        b      = 32'd1000;
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < N_DUT; i++) check($sformatf("async reset acc[%0d]", i), get_acc(i), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        random_run(200);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac.md
# mac

Single multiply-accumulate lane for the matrix accelerator. Each enabled cycle it multiplies `a_in` by `b_in` and adds the product into an internal accumulator. The accelerator instantiates MAC_UNITS copies and sums their `accum_out` values combinationally to form one dot-product result. The accumulator is registered; `clear` restarts a dot product.

## Interface
Parameters:
- DATA_WIDTH, 32: width of `a_in` and `b_in`.
- ACC_WIDTH, 32: width of the accumulator and `accum_out`; must be ≥ DATA_WIDTH.
- SIGNED, 1: 1 = two's-complement operands and accumulator; 0 = unsigned.
- SATURATE, 0: 0 = accumulator wraps modulo 2^ACC_WIDTH; 1 = clamps at the representable min/max.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  start a new dot product (discard the accumulator).
- enable  in  1  accumulate the current `a_in*b_in` product.
- a_in  in  DATA_WIDTH  multiplicand (row element of A).
- b_in  in  DATA_WIDTH  multiplier (column element of B).
- accum_out  out  ACC_WIDTH  current accumulator value; driven directly from the register.
- overflow  out  1  sticky flag: some accumulate since the last clear/reset wrapped or saturated.

## Operation
- Product p = a_in × b_in, computed at full 2·DATA_WIDTH width, signed or unsigned per SIGNED, then resized to ACC_WIDTH:
  - sign-extended when SIGNED=1;
  - truncated to the low ACC_WIDTH bits when narrower.
  - If truncation changes the value, that counts as overflow.
- Per-edge update, in priority order:
  - reset low: acc = 0, overflow = 0.
  - clear=1, enable=1: acc = p, with overflow = (p truncation lost information). The first product of a dot product is never dropped.
  - clear=1, enable=0: acc = 0, overflow = 0.
  - clear=0, enable=1: acc = acc + p. Overflow is detected from the sign/carry of the ACC_WIDTH+1-bit sum. On overflow:
    - SATURATE=0: store the wrapped sum and set `overflow`.
    - SATURATE=1: store max or min (unsigned: all-ones on carry) and set `overflow`.
  - clear=0, enable=0: hold acc and overflow.
- `overflow` stays set until clear or reset.
- Operands are sampled only when enable=1; X on `a_in`/`b_in` with enable=0 must not disturb the state.

## Timing
- Latency: one clock. An accumulate or clear on edge N is visible on `accum_out` after edge N.
- No handshake: `enable` may be held high continuously and each cycle accumulates.
- Reset values: accum_out = 0, overflow = 0. Reset asserts asynchronously and releases synchronously to clk, with a two-stage release synchronizer inside the block.
- Reset mid-accumulation discards the partial sum immediately.
- The multiply-add path is a single cycle. Pipelined multipliers are out of scope.

## Structure
- Shared package `mac_pkg`: default DATA_WIDTH/ACC_WIDTH constants, and functions for signed/unsigned saturation limits shared with the accelerator top.
- One natural sub-module: `mac_mult`, a combinational full-width signed/unsigned multiplier.
- The accumulate/saturate/overflow logic and the reset synchronizer live in `mac`.

## Test plan
- Reset: hold reset low while clear=0, enable=1, a=5, b=7 → accum_out=0 and overflow=0. Release reset → the first enabled edge gives accum_out=35.
- Dot product: drive clear=1, enable=1 with (1,4), then clear=0 with (2,5) and (3,6) → accum_out reads 4, 14, 32 on successive edges.
- Hold and clear:
  - enable=0 with random operands → accum_out stays 32.
  - clear=1, enable=0 → accum_out becomes 0 after one edge.
- Signed: SIGNED=1, clear+enable with a=−3 (0xFFFFFFFD), b=4 → accum_out=0xFFFFFFF4; then +(2,6) → 0x00000000.
- Wrap vs. saturate: acc=0x7FFFFFFF, enable with (1,1):
  - SATURATE=0 → 0x80000000 with overflow=1;
  - SATURATE=1 → 0x7FFFFFFF with overflow=1.
  - A subsequent clear drops overflow to 0.
- Async reset mid-run: assert reset between edges while accumulating → accum_out is 0 before the next clk edge.
